// File: rtl/cmd_pkt_framer.sv
// cmd_pkt_framer: frames UART bytes (55 | type | N | payload[N]) into
// a contiguous command burst with length, data and last qualifiers.
//
// Ports:
//   i_clk            clock, all logic on the rising edge
//   i_rst            asynchronous active-high reset
//   i_uart_rx_data   received byte
//   i_uart_rx_valid  one-cycle strobe for i_uart_rx_data
//   o_cmd_len        packet byte count N+3 during the burst, else 0
//   o_cmd_data       packet byte of the current beat, else 0
//   o_cmd_last       final beat of the burst
//   o_cmd_valid      beat qualifier, contiguous across the burst
//   o_pkt_err        one-cycle pulse when a packet is discarded
//   o_rx_overflow    one-cycle pulse when a byte is dropped
module cmd_pkt_framer #(
    parameter int P_MAX_PAYLOAD = 61,
    parameter int P_TIMEOUT     = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_uart_rx_data,
    input  logic       i_uart_rx_valid,
    output logic [7:0] o_cmd_len,
    output logic [7:0] o_cmd_data,
    output logic       o_cmd_last,
    output logic       o_cmd_valid,
    output logic       o_pkt_err,
    output logic       o_rx_overflow
);
    localparam int DEPTH = P_MAX_PAYLOAD + 3;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(P_TIMEOUT);
    localparam logic [CW-1:0] IDLE_MAX = CW'(P_TIMEOUT - 1);
    localparam logic [7:0]    HDR      = 8'h55;

    typedef enum logic [2:0] {
        S_HUNT,
        S_TYPE,
        S_LEN,
        S_PAYLOAD,
        S_SEND
    } state_t;

    state_t state_q, state_d;

    logic [7:0]    buf_mem [DEPTH];
    logic [AW-1:0] wr_idx_q;
    logic [AW-1:0] rd_idx_q;
    logic [AW-1:0] pay_len_q;
    logic [CW-1:0] idle_q;
    logic          rd_done_q;
    logic          hold_v_q;
    logic [7:0]    hold_d_q;

    logic          in_v;
    logic [7:0]    in_d;
    logic          collecting;
    logic          len_ok;
    logic          timeout;
    logic [AW-1:0] last_idx;
    logic          rd_last;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          err_set;
    logic          issue;
    logic          ovf_set;
    logic          hold_cap;

    // Outside SEND the held byte always goes first; a strobe in the
    // same cycle refills the holding register instead of being lost.
    assign in_v = (state_q != S_SEND) && (hold_v_q || i_uart_rx_valid);
    assign in_d = hold_v_q ? hold_d_q : i_uart_rx_data;

    assign collecting = state_q inside {S_TYPE, S_LEN, S_PAYLOAD};
    assign len_ok     = int'(in_d) <= P_MAX_PAYLOAD;
    assign timeout    = collecting && !in_v && (idle_q == IDLE_MAX);
    assign last_idx   = pay_len_q + AW'(2);
    assign rd_last    = rd_idx_q == last_idx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_HUNT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HUNT:
                if (in_v && in_d == HDR) state_d = S_TYPE;
            S_TYPE:
                if (in_v)         state_d = S_LEN;
                else if (timeout) state_d = S_HUNT;
            S_LEN:
                if (in_v) begin
                    if (!len_ok)             state_d = S_HUNT;
                    else if (in_d == 8'h00)  state_d = S_SEND;
                    else                     state_d = S_PAYLOAD;
                end else if (timeout) begin
                    state_d = S_HUNT;
                end
            S_PAYLOAD:
                if (in_v) begin
                    if (wr_idx_q == last_idx) state_d = S_SEND;
                end else if (timeout) begin
                    state_d = S_HUNT;
                end
            // Leave only once the last beat is on the outputs.
            S_SEND:
                if (o_cmd_last) state_d = S_HUNT;
            default:
                state_d = S_HUNT;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wr_idx_q;
        err_set = timeout;
        unique case (state_q)
            S_HUNT: begin
                wr_en   = in_v && (in_d == HDR);
                wr_addr = '0;
            end
            S_TYPE, S_PAYLOAD:
                wr_en = in_v;
            S_LEN: begin
                wr_en = in_v && len_ok;
                if (in_v && !len_ok) err_set = 1'b1;
            end
            default: ;
        endcase
        issue    = (state_q == S_SEND) && !rd_done_q;
        ovf_set  = i_uart_rx_valid && (state_q == S_SEND) && hold_v_q;
        hold_cap = i_uart_rx_valid && !ovf_set &&
                   ((state_q == S_SEND) || hold_v_q);
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) buf_mem[wr_addr] <= in_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            pay_len_q     <= '0;
            idle_q        <= '0;
            rd_done_q     <= 1'b0;
            hold_v_q      <= 1'b0;
            hold_d_q      <= '0;
            o_cmd_len     <= '0;
            o_cmd_data    <= '0;
            o_cmd_last    <= 1'b0;
            o_cmd_valid   <= 1'b0;
            o_pkt_err     <= 1'b0;
            o_rx_overflow <= 1'b0;
        end else begin
            if (wr_en)                  wr_idx_q <= wr_addr + AW'(1);
            else if (state_q == S_HUNT) wr_idx_q <= '0;

            if (state_q == S_LEN && wr_en) pay_len_q <= AW'(in_d);

            if (collecting && !in_v && !timeout) idle_q <= idle_q + CW'(1);
            else                                 idle_q <= '0;

            if (hold_cap) begin
                hold_v_q <= 1'b1;
                hold_d_q <= i_uart_rx_data;
            end else if (hold_v_q && state_q != S_SEND) begin
                hold_v_q <= 1'b0;
            end

            if (issue) begin
                rd_idx_q  <= rd_idx_q + AW'(1);
                rd_done_q <= rd_last;
            end else if (state_q != S_SEND) begin
                rd_idx_q  <= '0;
                rd_done_q <= 1'b0;
            end

            // Registered buffer read: beat i appears one cycle after issue.
            o_cmd_valid   <= issue;
            o_cmd_data    <= issue ? buf_mem[rd_idx_q] : 8'h00;
            o_cmd_len     <= issue ? 8'(pay_len_q) + 8'd3 : 8'h00;
            o_cmd_last    <= issue && rd_last;
            o_pkt_err     <= err_set;
            o_rx_overflow <= ovf_set;
        end
    end
endmodule

// File: doc/cmd_pkt_framer.md
CMD_PKT_FRAMER -- requirements
Module: cmd_pkt_framer

Interface
REQ-001 The block SHALL expose parameters, one per line:
- P_MAX_PAYLOAD, default 61: largest accepted payload byte count N.
- P_TIMEOUT, default 50000: maximum idle clocks allowed between bytes inside one packet.

REQ-002 The block SHALL expose ports, one per line (name, direction, width, meaning):
- i_clk, in, 1: single clock; all logic on rising edge.
- i_rst, in, 1: asynchronous, active-high reset.
- i_uart_rx_data, in, 8: received UART byte.
- i_uart_rx_valid, in, 1: one-cycle strobe qualifying i_uart_rx_data.
- o_cmd_len, out, 8: total packet byte count (N+3), held constant for the whole burst.
- o_cmd_data, out, 8: packet byte for the current beat.
- o_cmd_last, out, 1: high on the final beat of the burst.
- o_cmd_valid, out, 1: beat qualifier; high for contiguous cycles across the burst.
- o_pkt_err, out, 1: one-cycle pulse when a packet is discarded.
- o_rx_overflow, out, 1: one-cycle pulse when a byte is lost.

Function
REQ-003 The packet format SHALL be: byte0 = 0x55 header, byte1 = type, byte2 = N (payload length), then N payload bytes.
REQ-004 The block SHALL use states HUNT, TYPE, LEN, PAYLOAD, SEND.
REQ-005 HUNT: a byte equal to 0x55 SHALL be stored at buffer[0] and move to TYPE; any other byte SHALL be discarded silently (no o_pkt_err).
REQ-006 TYPE: any byte SHALL be stored at buffer[1] and move to LEN.
REQ-007 LEN: a byte N ≤ P_MAX_PAYLOAD SHALL be stored at buffer[2]. If N = 0, go to SEND; otherwise go to PAYLOAD.
REQ-008 LEN: a byte N > P_MAX_PAYLOAD SHALL pulse o_pkt_err and return to HUNT.
REQ-009 PAYLOAD: bytes SHALL be stored at buffer[3..N+2]. The Nth payload byte SHALL move to SEND.
REQ-010 Inside TYPE, LEN and PAYLOAD, an idle counter SHALL clear on every accepted byte and increment otherwise.
REQ-011 When the idle counter reaches P_TIMEOUT-1, the block SHALL pulse o_pkt_err, discard the partial packet and return to HUNT. The counter SHALL be inactive in HUNT and SEND.
REQ-012 Latency: if the completing byte is accepted in cycle T, the first beat (o_cmd_data = 0x55) SHALL appear in cycle T+2. This allows a 1-cycle buffer read.
REQ-013 The burst SHALL be N+3 consecutive valid cycles with no gaps, and o_cmd_data SHALL follow buffer order.
REQ-014 o_cmd_last SHALL be high only on beat N+3. o_cmd_valid SHALL deassert the cycle after last, and the state SHALL return to HUNT.
REQ-015 There is no backpressure: downstream SHALL accept every beat.
REQ-016 o_cmd_len SHALL equal N+3 (8-bit, ≤ 64) on every valid beat. When o_cmd_valid is low, o_cmd_len, o_cmd_data and o_cmd_last SHALL be 0.
REQ-017 A byte arriving during SEND (or in the cycle of entering SEND) SHALL be captured in a one-entry holding register. It SHALL be processed in HUNT in the first cycle after the burst ends.
REQ-018 A second byte arriving while the holding register is full SHALL be dropped with an o_rx_overflow pulse; the held byte SHALL be kept.
REQ-019 If a held byte is being processed in the same cycle a new byte strobes, the new byte SHALL be captured into the holding register. No byte is lost in that case.
REQ-020 Buffer depth SHALL be P_MAX_PAYLOAD+3 bytes. Write and read indices SHALL not wrap; they SHALL restart at 0 for each packet.

Reset
REQ-021 While i_rst is high, the state SHALL be HUNT, and the idle counter, indices and holding register SHALL be clear.
REQ-022 While i_rst is high, o_cmd_len = 0, o_cmd_data = 0, o_cmd_last = 0, o_cmd_valid = 0, o_pkt_err = 0 and o_rx_overflow = 0.
REQ-023 Reset asserted mid-packet or mid-burst SHALL force all outputs to 0 immediately (asynchronously). The partial packet SHALL be lost and nothing SHALL resume after release.
REQ-024 Buffer contents need not be cleared by reset.

Verification
REQ-025 Normal packet: bytes 55 01 01 03 at 10-cycle spacing -> 4-beat burst 55,01,01,03 starting 2 cycles after the 03 byte; o_cmd_len = 4 on all beats; last on beat 4.
REQ-026 Zero-length packet: 55 09 00 -> 3-beat burst 55,09,00 with o_cmd_len = 3. Junk bytes AA 12 before the 55 -> no burst for them and no o_pkt_err.
REQ-027 Bad length: 55 02 3E (62 > 61) -> o_pkt_err pulse and no burst. A following 55 02 03 11 22 33 -> 6-beat burst with o_cmd_len = 6.
REQ-028 Timeout (P_TIMEOUT = 100): 55 02 03 11, then 100-cycle gap -> o_pkt_err pulse. Then 55 04 01 07 -> normal 4-beat burst.
REQ-029 Collision during a 64-byte burst: one byte 55 arrives mid-burst -> held, and the next packet frames correctly. Two bytes 55 then 05 arrive mid-burst -> o_rx_overflow pulses once for the 05; 55 is kept.
REQ-030 Reset pulse on burst beat 10 -> o_cmd_valid = 0 in the same cycle. After release, packet 55 06 01 01 -> clean 4-beat burst.
